// File: rtl/pedestal_restorer.sv
// rtl/pedestal_restorer.sv - baseline (pedestal) tracker and subtractor with excursion veto
module pedestal_restorer #(
    parameter int W       = 5,
    parameter int THRESH  = 64,
    parameter int HOLDOFF = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic signed [15:0] x,
    output logic signed [15:0] y,
    output logic signed [15:0] pedestal,
    output logic               ped_valid
);

    localparam int AW = 16 + W + 1;

    typedef enum logic [1:0] {INIT, TRACK, HOLD} state_t;

    state_t             state;
    logic signed [15:0] in_reg;
    logic               smp_v;
    logic signed [AW-1:0] acc;
    logic [W-1:0]       cnt;
    logic [15:0]        hold_cnt;

    logic signed [16:0] diff;
    logic [16:0]        mag;
    logic               excursion;
    logic signed [15:0] y_sat;
    logic signed [AW-1:0] acc_sum;
    logic signed [15:0] ped_new;
    logic               win_done;
    logic               do_acc;

    // Residual, its magnitude and the running sum for the sample sitting in in_reg
    always_comb begin
        diff      = {in_reg[15], in_reg} - {pedestal[15], pedestal};
        mag       = diff[16] ? (17'd0 - diff) : diff;
        excursion = (mag > 17'(THRESH));
        if (diff[16] != diff[15]) begin
            y_sat = diff[16] ? 16'sh8000 : 16'sh7fff;
        end else begin
            y_sat = diff[15:0];
        end
        acc_sum  = acc + {{(AW-16){in_reg[15]}}, in_reg};
        // Floor division by 2^W: the arithmetic shift keeps just these 16 bits
        ped_new  = acc_sum[W +: 16];
        win_done = (cnt == '1);
        // Excursions veto accumulation in TRACK; HOLD never accumulates
        do_acc   = smp_v && ((state == INIT) || ((state == TRACK) && !excursion));
    end

    // Stage 1: capture the sample on enabled edges only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_reg <= '0;
            smp_v  <= 1'b0;
        end else begin
            smp_v <= enable;
            if (enable) begin
                in_reg <= x;
            end
        end
    end

    // Stage 2: pedestal-subtracted, saturated output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y <= '0;
        end else if (smp_v) begin
            y <= y_sat;
        end
    end

    // Estimation FSM: windowed averaging, excursion veto and holdoff
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            acc       <= '0;
            cnt       <= '0;
            hold_cnt  <= '0;
            pedestal  <= '0;
            ped_valid <= 1'b0;
        end else if (smp_v) begin
            if (do_acc) begin
                if (win_done) begin
                    pedestal  <= ped_new;
                    ped_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    state     <= TRACK;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + 1'b1;
                end
            end
            case (state)
                INIT: ;
                TRACK: begin
                    if (excursion) begin
                        acc      <= '0;
                        cnt      <= '0;
                        hold_cnt <= 16'(HOLDOFF - 1);
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (excursion) begin
                        hold_cnt <= 16'(HOLDOFF - 1);
                    end else if (hold_cnt == 16'd0) begin
                        state <= TRACK;
                    end else begin
                        hold_cnt <= hold_cnt - 16'd1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pedestal_restorer.sv
// tb/tb_pedestal_restorer.sv - table-driven self-checking bench for pedestal_restorer
module tb_pedestal_restorer;

    logic               clk;
    logic               reset;
    logic               enable;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] pedestal;
    logic               ped_valid;

    int checks;
    int errors;

    typedef struct {
        logic               en;
        logic signed [15:0] xv;
        logic signed [15:0] ey;
        logic signed [15:0] eped;
        logic               ev;
    } vec_t;

    vec_t vq[$];

    pedestal_restorer dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .x         (x),
        .y         (y),
        .pedestal  (pedestal),
        .ped_valid (ped_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected values of a record are the outputs one edge after it is driven
    function automatic void add(input logic en, input int xv, input int ey, input int ep, input logic ev);
        vec_t e;
        e.en   = en;
        e.xv   = 16'(xv);
        e.ey   = 16'(ey);
        e.eped = 16'(ep);
        e.ev   = ev;
        vq.push_back(e);
    endfunction

    function automatic void add_n(input int n, input int xv, input int ey, input int ep, input logic ev);
        for (int k = 0; k < n; k++) add(1'b1, xv, ey, ep, ev);
    endfunction

    // Idle record: outputs must hold whatever the previous record produced
    function automatic void add_idle(input int xv);
        vec_t e;
        e    = vq[vq.size()-1];
        e.en = 1'b0;
        e.xv = 16'(xv);
        vq.push_back(e);
    endfunction

    task automatic cmp(input string name, input int idx, input int got, input int want, input string what);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s[%0d] %s got %0d expected %0d", name, idx, what, got, want);
        end
    endtask

    task automatic run_table(input string name);
        int n;
        n = vq.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                enable = vq[i].en;
                x      = vq[i].xv;
            end else begin
                enable = 1'b0;
            end
            @(posedge clk);
            #1;
            if (i > 0) begin
                cmp(name, i-1, int'(y),         int'(vq[i-1].ey),   "y");
                cmp(name, i-1, int'(pedestal),  int'(vq[i-1].eped), "pedestal");
                cmp(name, i-1, int'(ped_valid), int'(vq[i-1].ev),   "ped_valid");
            end
        end
        vq.delete();
        enable = 1'b0;
    endtask

    task automatic do_reset(input string name);
        reset  = 1'b1;
        enable = 1'b0;
        x      = '0;
        #1;
        cmp(name, 0, int'(y),         0, "reset y");
        cmp(name, 0, int'(pedestal),  0, "reset pedestal");
        cmp(name, 0, int'(ped_valid), 0, "reset ped_valid");
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        enable = 1'b0;
        x      = '0;
        #2;

        // Lock at 1000, excursion to 1500, holdoff restarted mid-HOLD, relock at 1010
        do_reset("rst_a");
        add_n(31, 1000, 1000, 0, 1'b0);
        add(1'b1, 1000, 1000, 1000, 1'b1);
        add_n(10, 1000, 0, 1000, 1'b1);
        add_n(4, 1500, 500, 1000, 1'b1);
        add_n(100, 1010, 10, 1000, 1'b1);
        add(1'b1, 1500, 500, 1000, 1'b1);
        add_n(287, 1010, 10, 1000, 1'b1);
        add(1'b1, 1010, 10, 1010, 1'b1);
        add_n(3, 1010, 0, 1010, 1'b1);
        run_table("lock_hold");

        // Negative floor average and excursion far above threshold
        do_reset("rst_b");
        for (int k = 0; k < 32; k++) begin
            add(1'b1, (k % 2 == 0) ? -1 : -2, (k % 2 == 0) ? -1 : -2,
                (k == 31) ? -2 : 0, (k == 31));
        end
        add(1'b1, 1065, 1067, -2, 1'b1);
        add(1'b1, -2, 0, -2, 1'b1);
        run_table("floor");

        // Threshold boundary: |diff| = THRESH accepted, THRESH+1 vetoed
        do_reset("rst_c");
        add_n(31, 0, 0, 0, 1'b0);
        add(1'b1, 0, 0, 0, 1'b1);
        add_n(31, -64, -64, 0, 1'b1);
        add(1'b1, -64, -64, -64, 1'b1);
        add_n(31, 0, 64, -64, 1'b1);
        add(1'b1, 0, 64, 0, 1'b1);
        add_n(40, 65, 65, 0, 1'b1);
        run_table("thresh");

        // Saturation at both rails
        do_reset("rst_d");
        add_n(31, -32768, -32768, 0, 1'b0);
        add(1'b1, -32768, -32768, -32768, 1'b1);
        add(1'b1, 32767, 32767, -32768, 1'b1);
        run_table("sat_hi");
        do_reset("rst_e");
        add_n(31, 32767, 32767, 0, 1'b0);
        add(1'b1, 32767, 32767, 32767, 1'b1);
        add(1'b1, -32768, -32768, 32767, 1'b1);
        run_table("sat_lo");

        // Enable toggling every clock, then a long idle freeze mid-HOLD
        do_reset("rst_f");
        for (int k = 0; k < 32; k++) begin
            add(1'b1, 1000, 1000, (k == 31) ? 1000 : 0, (k == 31));
            add_idle(7);
        end
        add_n(3, 1000, 0, 1000, 1'b1);
        add(1'b1, 1500, 500, 1000, 1'b1);
        for (int k = 0; k < 50; k++) add_idle(5000);
        add(1'b1, 1000, 0, 1000, 1'b1);
        run_table("toggle");

        // Asynchronous reset pulse between edges after 20 samples
        do_reset("rst_g");
        add_n(20, 1000, 1000, 0, 1'b0);
        run_table("pre_async");
        #2;
        reset = 1'b1;
        #1;
        cmp("async_rst", 0, int'(y),         0, "y");
        cmp("async_rst", 0, int'(pedestal),  0, "pedestal");
        cmp("async_rst", 0, int'(ped_valid), 0, "ped_valid");
        reset = 1'b0;
        add_n(31, 1000, 1000, 0, 1'b0);
        add(1'b1, 1000, 1000, 1000, 1'b1);
        add(1'b1, 1000, 0, 1000, 1'b1);
        run_table("post_async");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
